// File: rtl/load_ext_pkg.sv
// Shared load/store-path constants.
// Load-op encoding and word width used by the memory stage.
package load_ext_pkg;

   localparam int DW = 32;

   localparam logic [2:0] LD_LW  = 3'b000;
   localparam logic [2:0] LD_LBU = 3'b001;
   localparam logic [2:0] LD_LB  = 3'b010;
   localparam logic [2:0] LD_LHU = 3'b011;
   localparam logic [2:0] LD_LH  = 3'b100;

   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/load_ext_comb.sv
// Load data extract / extend and misalignment check.
// Purely combinational; sits in front of the stage register.
module load_ext_comb
   import load_ext_pkg::*;
(
   input  logic [2:0]    ld_op,
   input  logic [1:0]    addr1_0,
   input  logic [DW-1:0] dm_rdata,
   output logic [DW-1:0] ext_data,
   output logic          misalign
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // pick the addressed byte and halfword lanes
   always_comb begin
      byte_sel = dm_rdata[7:0];
      unique case (addr1_0)
         2'b00: byte_sel = dm_rdata[7:0];
         2'b01: byte_sel = dm_rdata[15:8];
         2'b10: byte_sel = dm_rdata[23:16];
         2'b11: byte_sel = dm_rdata[31:24];
         default: byte_sel = dm_rdata[7:0];
      endcase
      half_sel = addr1_0[1] ? dm_rdata[31:16] : dm_rdata[15:0];
   end

   // extend per op; reserved ops always flag an error
   always_comb begin
      ext_data = '0;
      misalign = 1'b0;
      unique case (ld_op)
         LD_LW: begin
            ext_data = dm_rdata;
            misalign = (addr1_0 != 2'b00);
         end
         LD_LBU: ext_data = {24'h0, byte_sel};
         LD_LB:  ext_data = {{24{byte_sel[7]}}, byte_sel};
         LD_LHU: begin
            ext_data = {16'h0, half_sel};
            misalign = addr1_0[0];
         end
         LD_LH: begin
            ext_data = {{16{half_sel[15]}}, half_sel};
            misalign = addr1_0[0];
         end
         default: begin
            ext_data = '0;
            misalign = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/load_ext_stage.sv
// Registered load-data path into write-back.
// Owns stall/flush control and the load error counter.
module load_ext_stage
   import load_ext_pkg::*;
#(
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic          ld_valid,
   input  logic [2:0]    ld_op,
   input  logic [1:0]    addr1_0,
   input  logic [DW-1:0] dm_rdata,
   input  logic [RW-1:0] ld_rd,
   output logic          wb_we,
   output logic [RW-1:0] wb_rd,
   output logic [DW-1:0] wb_data,
   output logic          ld_err,
   output logic          err_sticky,
   output logic [7:0]    err_cnt
);

   logic [DW-1:0] ext_data;
   logic          misalign;

   load_ext_comb u_comb (
      .ld_op    (ld_op),
      .addr1_0  (addr1_0),
      .dm_rdata (dm_rdata),
      .ext_data (ext_data),
      .misalign (misalign)
   );

   // stage register: reset > stall (hold) > flush (bubble) > load
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_we      <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         ld_err     <= 1'b0;
         err_sticky <= 1'b0;
         err_cnt    <= '0;
      end else if (!stall) begin
         if (flush) begin
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
            ld_err  <= 1'b0;
         end else if (ld_valid) begin
            wb_rd   <= ld_rd;
            ld_err  <= misalign;
            wb_we   <= !misalign && (ld_rd != '0);
            wb_data <= misalign ? '0 : ext_data;
            if (misalign) begin
               err_sticky <= 1'b1;
               if (err_cnt != ERR_CNT_MAX)
                  err_cnt <= err_cnt + 8'd1;
            end
         end else begin
            wb_we   <= 1'b0;
            wb_rd   <= ld_rd;
            wb_data <= '0;
            ld_err  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_load_ext_stage.sv
// Directed bench for load_ext_stage.
// Expected outputs are queued at drive time, popped after the edge.
module tb_load_ext_stage;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
      logic        sticky;
      logic [7:0]  cnt;
      bit          chk_rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, stall, flush, ld_valid;
   logic [2:0]  ld_op;
   logic [1:0]  addr1_0;
   logic [31:0] dm_rdata;
   logic [4:0]  ld_rd;
   logic        wb_we, ld_err, err_sticky;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [7:0]  err_cnt;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t cur;
   int   m_cnt = 0;
   bit   m_sticky = 1'b0;

   always #5 clk = ~clk;

   load_ext_stage #(.RW(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .flush      (flush),
      .ld_valid   (ld_valid),
      .ld_op      (ld_op),
      .addr1_0    (addr1_0),
      .dm_rdata   (dm_rdata),
      .ld_rd      (ld_rd),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .ld_err     (ld_err),
      .err_sticky (err_sticky),
      .err_cnt    (err_cnt)
   );

   function automatic exp_t mk(bit we, logic [4:0] rd,
                               logic [31:0] data, bit err, bit chk_rd);
      exp_t e;
      if (err) begin
         m_sticky = 1'b1;
         if (m_cnt < 255) m_cnt++;
      end
      e.we     = we;
      e.rd     = rd;
      e.data   = data;
      e.err    = err;
      e.sticky = m_sticky;
      e.cnt    = 8'(m_cnt);
      e.chk_rd = chk_rd;
      cur = e;
      return e;
   endfunction

   function automatic exp_t mk_rst();
      m_cnt    = 0;
      m_sticky = 1'b0;
      return mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
      end
   endtask

   task automatic cyc(string tag, bit rs, bit st, bit fl, bit v,
                      logic [2:0] op, logic [1:0] a,
                      logic [31:0] d, logic [4:0] rd, exp_t e);
      exp_t x;
      reset    = rs;
      stall    = st;
      flush    = fl;
      ld_valid = v;
      ld_op    = op;
      addr1_0  = a;
      dm_rdata = d;
      ld_rd    = rd;
      sb.push_back(e);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk({tag, ".we"},     32'(wb_we),      32'(x.we));
      chk({tag, ".data"},   wb_data,         x.data);
      chk({tag, ".err"},    32'(ld_err),     32'(x.err));
      chk({tag, ".sticky"}, 32'(err_sticky), 32'(x.sticky));
      chk({tag, ".cnt"},    32'(err_cnt),    32'(x.cnt));
      if (x.chk_rd)
         chk({tag, ".rd"}, 32'(wb_rd), 32'(x.rd));
   endtask

   localparam logic [31:0] W = 32'h8A7F_C3E1;

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; ld_valid = 1'b0;
      ld_op = 3'b000; addr1_0 = 2'b00; dm_rdata = '0; ld_rd = '0;
      @(posedge clk);
      #1;

      cyc("rst0", 1, 1, 0, 1, 3'b000, 2'b00, W, 5'd5, mk_rst());

      cyc("lb0",  0, 0, 0, 1, 3'b010, 2'b00, W, 5'd5,
          mk(1, 5'd5, 32'hFFFF_FFE1, 0, 1));
      cyc("lbu1", 0, 0, 0, 1, 3'b001, 2'b01, W, 5'd5,
          mk(1, 5'd5, 32'h0000_00C3, 0, 1));
      cyc("lh2",  0, 0, 0, 1, 3'b100, 2'b10, W, 5'd5,
          mk(1, 5'd5, 32'hFFFF_8A7F, 0, 1));
      cyc("lhu0", 0, 0, 0, 1, 3'b011, 2'b00, W, 5'd5,
          mk(1, 5'd5, 32'h0000_C3E1, 0, 1));
      cyc("lw0",  0, 0, 0, 1, 3'b000, 2'b00, W, 5'd5,
          mk(1, 5'd5, W, 0, 1));
      cyc("lhu2", 0, 0, 0, 1, 3'b011, 2'b10, W, 5'd7,
          mk(1, 5'd7, 32'h0000_8A7F, 0, 1));
      cyc("lb1",  0, 0, 0, 1, 3'b010, 2'b01, W, 5'd7,
          mk(1, 5'd7, 32'hFFFF_FFC3, 0, 1));
      cyc("lb2",  0, 0, 0, 1, 3'b010, 2'b10, W, 5'd7,
          mk(1, 5'd7, 32'h0000_007F, 0, 1));

      cyc("mis_lw", 0, 0, 0, 1, 3'b000, 2'b10, W, 5'd5,
          mk(0, 5'd5, 32'h0, 1, 1));
      cyc("mis_lh", 0, 0, 0, 1, 3'b100, 2'b01, W, 5'd6,
          mk(0, 5'd6, 32'h0, 1, 1));
      cyc("mis_rsv", 0, 0, 0, 1, 3'b111, 2'b00, W, 5'd8,
          mk(0, 5'd8, 32'h0, 1, 1));
      cyc("err_st", 0, 1, 0, 1, 3'b101, 2'b11, W, 5'd9, cur);
      cyc("err_st2", 0, 1, 0, 1, 3'b000, 2'b01, W, 5'd9, cur);

      cyc("lb3", 0, 0, 0, 1, 3'b010, 2'b11, 32'h7F00_0000, 5'd9,
          mk(1, 5'd9, 32'h0000_007F, 0, 1));
      for (int i = 0; i < 3; i++)
         cyc("stall", 0, 1, 0, 1, 3'b000, 2'b00,
             32'h1234_5678 + 32'(i), 5'd3, cur);

      cyc("flush", 0, 0, 1, 1, 3'b000, 2'b00, 32'h1111_2222, 5'd4,
          mk(0, 5'd0, 32'h0, 0, 0));
      cyc("lw6", 0, 0, 0, 1, 3'b000, 2'b00, 32'hCAFE_BABE, 5'd6,
          mk(1, 5'd6, 32'hCAFE_BABE, 0, 1));
      cyc("st_fl", 0, 1, 1, 1, 3'b000, 2'b00, 32'h5555_AAAA, 5'd2, cur);

      cyc("rd0", 0, 0, 0, 1, 3'b000, 2'b00, 32'hDEAD_BEEF, 5'd0,
          mk(0, 5'd0, 32'hDEAD_BEEF, 0, 1));
      cyc("novld", 0, 0, 0, 0, 3'b111, 2'b01, 32'hFFFF_FFFF, 5'd3,
          mk(0, 5'd3, 32'h0, 0, 0));

      for (int i = 0; i < 300; i++)
         cyc("sat", 0, 0, 0, 1, 3'b000, 2'b01, W, 5'd1,
             mk(0, 5'd1, 32'h0, 1, 1));
      chk("sat_final", 32'(err_cnt), 32'd255);

      cyc("rst1", 1, 1, 0, 1, 3'b000, 2'b00, W, 5'd5, mk_rst());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_ext_stage.md
Name: load_ext_stage

Overview:
- Registered load-data path for the memory stage: the reader side of the sub-word store path.
- Takes the 32-bit word read from data memory, the load type and the low address bits.
- Selects and sign/zero-extends the addressed byte or halfword and detects misaligned loads.
- Presents the result one cycle later to write-back, honouring pipeline stall and flush.

Parameters:
- DW, 32, data word width (fixed at 32; sub-word slicing assumes 4 bytes)
- RW, 5, register-file index width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold all stage registers this cycle
- flush  input  1  replace captured load with a bubble
- ld_valid  input  1  a load is present in the memory stage this cycle
- ld_op  input  3  000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh; 101-111 reserved
- addr1_0  input  2  low two bits of the effective address
- dm_rdata  input  32  word read from data memory (word-aligned)
- ld_rd  input  RW  destination register index
- wb_we  output  1  write-back enable
- wb_rd  output  RW  destination index to write-back
- wb_data  output  32  extended load data
- ld_err  output  1  one-cycle pulse: misaligned or reserved-op load retired
- err_sticky  output  1  set on any ld_err, cleared only by reset
- err_cnt  output  8  count of ld_err pulses since reset, saturating at 255

Behaviour:
- Reset (reset=1 at clk edge): wb_we=0, wb_rd=0, wb_data=0, ld_err=0, err_sticky=0, err_cnt=0. Reset has priority over stall and flush.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Extraction (combinational before the register):
  - lw: the whole word.
  - lb/lbu: byte dm_rdata[8*a+7:8*a], where a = addr1_0.
  - lh/lhu: halfword dm_rdata[15:0] for addr1_0=00, dm_rdata[31:16] for addr1_0=10.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-fill.
- Misalignment, evaluated when ld_valid=1:
  - lw with addr1_0 != 00;
  - lh/lhu with addr1_0[0]=1;
  - any reserved op.
- On misalignment the next cycle gives ld_err=1, wb_we=0 and wb_data=0; wb_rd is still captured.
- Aligned valid load: next cycle wb_we = (ld_rd != 0), ld_err=0.
- ld_valid=0: next cycle wb_we=0, ld_err=0, wb_data=0.
- stall=1 (and reset=0): all outputs hold their values; err_cnt and err_sticky do not change; ld_err holds, so a held error is not re-counted.
- flush=1 (stall=0, reset=0): next cycle is a bubble (wb_we=0, ld_err=0, wb_data=0), regardless of ld_valid.
- Simultaneous stall and flush: stall wins and outputs hold.
- err_cnt increments in the same edge that registers ld_err=1. At 255 it stays at 255.
- err_sticky is set in the same edge.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - the load-op constants (LD_LW=3'b000, LD_LBU=3'b001, LD_LB=3'b010, LD_LHU=3'b011, LD_LH=3'b100);
  - the width constant DW=32, so the store-side byte-enable encoding and this decode stay consistent.
- One natural sub-module, load_ext_comb: the purely combinational extract/extend/misalign check (ld_op, addr1_0, dm_rdata -> ext_data, misalign).
- load_ext_stage instantiates it and owns the pipeline register, stall/flush control and error counter.

Test Plan:
- All ops on dm_rdata=32'h8A7F_C3E1 with ld_rd=5:
  - lb addr 00 -> wb_data=32'hFFFF_FFE1, wb_we=1;
  - lbu addr 01 -> 32'h0000_00C3;
  - lh addr 10 -> 32'hFFFF_8A7F;
  - lhu addr 00 -> 32'h0000_C3E1;
  - lw addr 00 -> 32'h8A7F_C3E1.
  - All appear one cycle after the load is presented.
- Misaligned loads: lw addr 10, then lh addr 01, then op 3'b111 addr 00 -> three ld_err pulses, wb_we=0 each, err_sticky=1, err_cnt=3.
- Stall hold: lb addr 11 on 32'h7F00_0000 (result 32'h0000_007F), then stall=1 for 3 cycles with new inputs -> wb_data stays 32'h0000_007F and wb_we stays 1 for all 3 cycles.
- Flush and priority:
  - valid lw with flush=1 -> next cycle wb_we=0, wb_data=0;
  - stall=1 and flush=1 together -> previous outputs held.
- rd zero: lw to ld_rd=0 -> wb_we=0, ld_err=0, wb_data=loaded word.
- Reset and saturation:
  - 300 consecutive misaligned loads -> err_cnt=255;
  - assert reset with stall=1 -> next cycle all outputs 0, err_cnt=0, err_sticky=0.
